// File: rtl/ysyx_22041071_wb.sv
// rtl/ysyx_22041071_wb.sv - writeback stage: register file, commit reporting, perf counters, ebreak halt
module ysyx_22041071_wb #(
  parameter logic HALT_ON_EBREAK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid6,
  output logic        ready6,
  input  logic [63:0] PC6,
  input  logic [31:0] Ins5,
  input  logic        reg_w_en4,
  input  logic [4:0]  rdest3,
  input  logic [63:0] WB_data1,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [63:0] rs1_data,
  output logic [63:0] rs2_data,
  output logic        commit_valid,
  output logic [63:0] commit_pc,
  output logic [31:0] commit_ins,
  output logic        commit_wen,
  output logic [4:0]  commit_wdest,
  output logic [63:0] commit_wdata,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt,
  output logic        halted,
  output logic [63:0] trap_code
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  state_t      state_next;
  logic        hs;
  logic        wr_fire;
  logic        enter_halt;
  logic [63:0] x10_view;
  logic [63:0] regs [0:31];

  assign halted  = (state == HALT);
  assign ready6  = ~halted;
  assign hs      = valid6 & ready6;
  assign wr_fire = hs & reg_w_en4 & (rdest3 != 5'd0);

  // Read ports: x0 is hardwired zero, a same-cycle write to the address is forwarded
  always_comb begin
    rs1_data = 64'd0;
    rs2_data = 64'd0;
    if (rs1_addr != 5'd0) begin
      rs1_data = (wr_fire && rdest3 == rs1_addr) ? WB_data1 : regs[rs1_addr];
    end
    if (rs2_addr != 5'd0) begin
      rs2_data = (wr_fire && rdest3 == rs2_addr) ? WB_data1 : regs[rs2_addr];
    end
  end

  // x10 as it will look after this cycle's write, so an ebreak that also writes a0 reports the new value
  always_comb begin
    x10_view = (wr_fire && rdest3 == 5'd10) ? WB_data1 : regs[10];
  end

  // Next-state logic: only a committed ebreak moves RUN to HALT; HALT is left only through reset
  always_comb begin
    state_next = state;
    enter_halt = 1'b0;
    if (state == RUN && hs && Ins5 == EBREAK && HALT_ON_EBREAK) begin
      state_next = HALT;
      enter_halt = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Register file write; reset clears every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 64'd0;
      end
    end else if (wr_fire) begin
      regs[rdest3] <= WB_data1;
    end
  end

  // Commit record: captured on a handshake, pulse lasts one cycle, payload held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_valid <= 1'b0;
      commit_pc    <= 64'd0;
      commit_ins   <= 32'd0;
      commit_wen   <= 1'b0;
      commit_wdest <= 5'd0;
      commit_wdata <= 64'd0;
    end else begin
      commit_valid <= hs;
      if (hs) begin
        commit_pc    <= PC6;
        commit_ins   <= Ins5;
        commit_wen   <= reg_w_en4 & (rdest3 != 5'd0);
        commit_wdest <= rdest3;
        commit_wdata <= WB_data1;
      end
    end
  end

  // Performance counters: cycles run while not halted, instret counts handshakes
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= 64'd0;
      instret_cnt <= 64'd0;
    end else begin
      if (!halted) begin
        cycle_cnt <= cycle_cnt + 64'd1;
      end
      if (hs) begin
        instret_cnt <= instret_cnt + 64'd1;
      end
    end
  end

  // Trap code is captured from a0 on the cycle the stage decides to halt
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_code <= 64'd0;
    end else if (enter_halt) begin
      trap_code <= x10_view;
    end
  end

endmodule

// File: tb/tb_ysyx_22041071_wb.sv
// tb/tb_ysyx_22041071_wb.sv - directed self-checking bench for the writeback stage
module tb_ysyx_22041071_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid6;
  logic        ready6;
  logic [63:0] PC6;
  logic [31:0] Ins5;
  logic        reg_w_en4;
  logic [4:0]  rdest3;
  logic [63:0] WB_data1;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [31:0] commit_ins;
  logic        commit_wen;
  logic [4:0]  commit_wdest;
  logic [63:0] commit_wdata;
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
  logic        halted;
  logic [63:0] trap_code;

  int passed = 0;
  int total  = 0;

  logic [63:0] exp_cycle;
  logic [63:0] exp_instret;
  logic        exp_halted;

  ysyx_22041071_wb #(.HALT_ON_EBREAK(1'b1)) dut (
    .clk(clk), .reset(reset), .valid6(valid6), .ready6(ready6),
    .PC6(PC6), .Ins5(Ins5), .reg_w_en4(reg_w_en4), .rdest3(rdest3),
    .WB_data1(WB_data1), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .commit_valid(commit_valid),
    .commit_pc(commit_pc), .commit_ins(commit_ins), .commit_wen(commit_wen),
    .commit_wdest(commit_wdest), .commit_wdata(commit_wdata),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .halted(halted),
    .trap_code(trap_code)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle; the cycle model follows the halt state
  task automatic step;
    @(posedge clk);
    #1;
    if (!exp_halted) exp_cycle = exp_cycle + 64'd1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_cycle   = 64'd0;
    exp_instret = 64'd0;
    exp_halted  = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic wen, input logic [4:0] rd, input logic [63:0] d);
    valid6 = v; PC6 = pc; Ins5 = ins; reg_w_en4 = wen; rdest3 = rd; WB_data1 = d;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b1, 64'h100, 32'h13, 1'b1, 5'd3, 64'h55);
    @(posedge clk);
    do_reset();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0);
    rs1_addr = 5'd3; rs2_addr = 5'd0;
    #1;
    total++; if (cycle_cnt !== 64'd0) $display("FAIL reset_cycle got %h expected 0", cycle_cnt); else passed++;
    total++; if (instret_cnt !== 64'd0) $display("FAIL reset_instret got %h expected 0", instret_cnt); else passed++;
    total++; if (ready6 !== 1'b1 || halted !== 1'b0) $display("FAIL reset_ready got ready6=%b halted=%b expected 1/0", ready6, halted); else passed++;
    total++; if (commit_valid !== 1'b0 || commit_pc !== 64'd0) $display("FAIL reset_commit got valid=%b pc=%h expected 0/0", commit_valid, commit_pc); else passed++;
    total++; if (rs1_data !== 64'd0) $display("FAIL reset_x3 got %h expected 0", rs1_data); else passed++;
  endtask

  task automatic test_bypass;
    drive(1'b1, 64'h8000_0000, 32'h0000_0013, 1'b1, 5'd5, 64'hDEAD_BEEF);
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    #1;
    total++; if (rs1_data !== 64'hDEAD_BEEF) $display("FAIL bypass_rs1 got %h expected deadbeef", rs1_data); else passed++;
    total++; if (rs2_data !== 64'hDEAD_BEEF) $display("FAIL bypass_rs2 got %h expected deadbeef", rs2_data); else passed++;
    step();
    exp_instret = exp_instret + 64'd1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0);
    #1;
    total++; if (commit_valid !== 1'b1) $display("FAIL bypass_commit_valid got %b expected 1", commit_valid); else passed++;
    total++; if (commit_wdest !== 5'd5 || commit_wen !== 1'b1) $display("FAIL bypass_commit_dest got %0d/%b expected 5/1", commit_wdest, commit_wen); else passed++;
    total++; if (commit_pc !== 64'h8000_0000 || commit_ins !== 32'h13 || commit_wdata !== 64'hDEAD_BEEF) $display("FAIL bypass_payload got pc=%h ins=%h d=%h expected 80000000/13/deadbeef", commit_pc, commit_ins, commit_wdata); else passed++;
    total++; if (rs1_data !== 64'hDEAD_BEEF) $display("FAIL stored_x5 got %h expected deadbeef", rs1_data); else passed++;
    total++; if (instret_cnt !== exp_instret) $display("FAIL bypass_instret got %h expected %h", instret_cnt, exp_instret); else passed++;
    step();
    total++; if (commit_valid !== 1'b0 || commit_pc !== 64'h8000_0000) $display("FAIL commit_hold got valid=%b pc=%h expected 0/80000000", commit_valid, commit_pc); else passed++;
  endtask

  task automatic test_x0;
    drive(1'b1, 64'h8000_0004, 32'h0000_0093, 1'b1, 5'd0, 64'h1234);
    rs1_addr = 5'd0; rs2_addr = 5'd5;
    #1;
    total++; if (rs1_data !== 64'd0) $display("FAIL x0_bypass got %h expected 0", rs1_data); else passed++;
    step();
    exp_instret = exp_instret + 64'd1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0);
    #1;
    total++; if (commit_valid !== 1'b1 || commit_wen !== 1'b0) $display("FAIL x0_commit got valid=%b wen=%b expected 1/0", commit_valid, commit_wen); else passed++;
    total++; if (rs1_data !== 64'd0 || rs2_data !== 64'hDEAD_BEEF) $display("FAIL x0_read got x0=%h x5=%h expected 0/deadbeef", rs1_data, rs2_data); else passed++;
  endtask

  task automatic test_idle;
    int bad = 0;
    drive(1'b0, 64'h0, 32'h0, 1'b1, 5'd6, 64'h77);
    for (int i = 0; i < 10; i++) begin
      step();
      if (commit_valid !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL idle_commit got %0d pulses expected 0", bad); else passed++;
    total++; if (cycle_cnt !== exp_cycle) $display("FAIL idle_cycle got %h expected %h", cycle_cnt, exp_cycle); else passed++;
    total++; if (instret_cnt !== exp_instret) $display("FAIL idle_instret got %h expected %h", instret_cnt, exp_instret); else passed++;
    rs1_addr = 5'd6;
    #1;
    total++; if (rs1_data !== 64'd0) $display("FAIL idle_nowrite got %h expected 0", rs1_data); else passed++;
  endtask

  task automatic test_ebreak;
    int bad = 0;
    drive(1'b1, 64'h8000_0010, 32'h0000_0513, 1'b1, 5'd10, 64'h0);
    step();
    exp_instret = exp_instret + 64'd1;
    drive(1'b1, 64'h8000_0014, 32'h0010_0073, 1'b0, 5'd0, 64'h0);
    step();
    exp_instret = exp_instret + 64'd1;
    exp_halted  = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0);
    #1;
    total++; if (halted !== 1'b1 || ready6 !== 1'b0) $display("FAIL ebreak_halt got halted=%b ready6=%b expected 1/0", halted, ready6); else passed++;
    total++; if (trap_code !== 64'd0) $display("FAIL ebreak_trap got %h expected 0", trap_code); else passed++;
    total++; if (commit_valid !== 1'b1 || commit_ins !== 32'h0010_0073) $display("FAIL ebreak_commit got valid=%b ins=%h expected 1/00100073", commit_valid, commit_ins); else passed++;
    total++; if (instret_cnt !== exp_instret) $display("FAIL ebreak_instret got %h expected %h", instret_cnt, exp_instret); else passed++;
    total++; if (cycle_cnt !== exp_cycle) $display("FAIL ebreak_cycle got %h expected %h", cycle_cnt, exp_cycle); else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h8000_0018, 32'h0000_0393, 1'b1, 5'd7, 64'h99);
      step();
      drive(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0);
      step();
      if (commit_valid !== 1'b0) bad++;
    end
    rs1_addr = 5'd7;
    #1;
    total++; if (bad != 0) $display("FAIL halt_commits got %0d expected 0", bad); else passed++;
    total++; if (instret_cnt !== exp_instret || cycle_cnt !== exp_cycle) $display("FAIL halt_frozen got instret=%h cycle=%h expected %h/%h", instret_cnt, cycle_cnt, exp_instret, exp_cycle); else passed++;
    total++; if (rs1_data !== 64'd0) $display("FAIL halt_nowrite got %h expected 0", rs1_data); else passed++;
  endtask

  task automatic test_reset_mid_stream;
    do_reset();
    total++; if (ready6 !== 1'b1 || halted !== 1'b0) $display("FAIL rst_unhalt got ready6=%b halted=%b expected 1/0", ready6, halted); else passed++;
    drive(1'b1, 64'h200, 32'h13, 1'b1, 5'd1, 64'd11);
    step();
    drive(1'b1, 64'h204, 32'h13, 1'b1, 5'd2, 64'd22);
    step();
    drive(1'b1, 64'h208, 32'h13, 1'b1, 5'd3, 64'd33);
    do_reset();
    drive(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0);
    rs1_addr = 5'd1; rs2_addr = 5'd2;
    #1;
    total++; if (rs1_data !== 64'd0 || rs2_data !== 64'd0) $display("FAIL mid_rst_regs got x1=%h x2=%h expected 0/0", rs1_data, rs2_data); else passed++;
    rs1_addr = 5'd3; rs2_addr = 5'd5;
    #1;
    total++; if (rs1_data !== 64'd0 || rs2_data !== 64'd0) $display("FAIL mid_rst_x3x5 got x3=%h x5=%h expected 0/0", rs1_data, rs2_data); else passed++;
    total++; if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) $display("FAIL mid_rst_cnt got cycle=%h instret=%h expected 0/0", cycle_cnt, instret_cnt); else passed++;
    total++; if (commit_valid !== 1'b0 || commit_wdata !== 64'd0) $display("FAIL mid_rst_commit got valid=%b data=%h expected 0/0", commit_valid, commit_wdata); else passed++;
  endtask

  task automatic test_ebreak_bypass;
    drive(1'b1, 64'h300, 32'h0010_0073, 1'b1, 5'd10, 64'hCAFE);
    step();
    exp_instret = exp_instret + 64'd1;
    exp_halted  = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0);
    rs1_addr = 5'd10;
    #1;
    total++; if (trap_code !== 64'hCAFE) $display("FAIL trap_bypass got %h expected cafe", trap_code); else passed++;
    total++; if (rs1_data !== 64'hCAFE || halted !== 1'b1) $display("FAIL trap_x10 got x10=%h halted=%b expected cafe/1", rs1_data, halted); else passed++;
    total++; if (instret_cnt !== exp_instret || cycle_cnt !== exp_cycle) $display("FAIL trap_counts got instret=%h cycle=%h expected %h/%h", instret_cnt, cycle_cnt, exp_instret, exp_cycle); else passed++;
  endtask

  initial begin
    exp_cycle = 64'd0; exp_instret = 64'd0; exp_halted = 1'b0;
    reset = 1'b1;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    drive(1'b0, 64'h0, 32'h0, 1'b0, 5'd0, 64'h0);
    test_reset();
    test_bypass();
    test_x0();
    test_idle();
    test_ebreak();
    test_reset_mid_stream();
    test_ebreak_bypass();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
